sha_core_engine: RTL and testbench

- Iterative SHA-2 compression engine: one round per clock.
- Accepts one pre-padded message block per handshake and chains blocks of a multi-block message.
- Presents the right-justified, mode-truncated digest.
- Sits behind the SHA bus front-end; message padding is done upstream.

---
 rtl/sha_core_engine_pkg.sv | 128 ++++++++++++
 rtl/sha_core_engine_if.sv | 14 +
 rtl/sha_core_engine_msg_sched.sv | 31 +++
 rtl/sha_core_engine.sv | 95 +++++++++
 tb/tb_sha_core_engine.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_core_engine_pkg.sv
// Shared types, round constants, initial hash values and SHA-2 word functions.
// Words are carried as 64 bits; the 256 family keeps its upper 32 bits at zero.
package sha_core_engine_pkg;

    typedef enum logic [2:0] {
        sha1, sha224, sha256, sha384, sha512, sha512_224, sha512_256
    } mode_t;

    typedef logic [511:0] hash_t;
    typedef enum logic [1:0] {st_idle, st_run, st_fin} state_t;
    typedef logic [63:0] words8_t [8];

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam words8_t IV224 = '{64'hc1059ed8, 64'h367cd507, 64'h3070dd17, 64'hf70e5939,
                                  64'hffc00b31, 64'h68581511, 64'h64f98fa7, 64'hbefa4fa4};
    localparam words8_t IV256 = '{64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372, 64'ha54ff53a,
                                  64'h510e527f, 64'h9b05688c, 64'h1f83d9ab, 64'h5be0cd19};
    localparam words8_t IV384 = '{64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
                                  64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
    localparam words8_t IV512 = '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                                  64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam words8_t IV512_224 = '{64'h8c3d37c819544da2, 64'h73e1996689dcd4d6, 64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf,
                                      64'h0f6d2b697bd44da8, 64'h77e36f7304c48942, 64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1};
    localparam words8_t IV512_256 = '{64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2, 64'h2393b86b6f53b151, 64'h963877195940eabd,
                                      64'h96283ee2a88effe3, 64'hbe5e1e2553863992, 64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2};

    function automatic logic is_sha2(input mode_t m);
        return m inside {sha224, sha256, sha384, sha512, sha512_224, sha512_256};
    endfunction

    function automatic logic is_w64(input mode_t m);
        return m inside {sha384, sha512, sha512_224, sha512_256};
    endfunction

    function automatic logic [63:0] word_mask(input logic w64);
        return w64 ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
    endfunction

    function automatic words8_t iv_of(input mode_t m);
        words8_t z;
        foreach (z[i]) z[i] = '0;
        case (m)
            sha224:     return IV224;
            sha256:     return IV256;
            sha384:     return IV384;
            sha512:     return IV512;
            sha512_224: return IV512_224;
            sha512_256: return IV512_256;
            default:    return z;
        endcase
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input logic w64);
        logic [31:0] lo;
        if (w64) return (x >> n) | (x << (64 - n));
        lo = (x[31:0] >> n) | (x[31:0] << (32 - n));
        return {32'b0, lo};
    endfunction

    function automatic logic [63:0] bsig0(input logic [63:0] x, input logic w64);
        return w64 ? rotr(x, 28, 1'b1) ^ rotr(x, 34, 1'b1) ^ rotr(x, 39, 1'b1)
                   : rotr(x, 2, 1'b0) ^ rotr(x, 13, 1'b0) ^ rotr(x, 22, 1'b0);
    endfunction

    function automatic logic [63:0] bsig1(input logic [63:0] x, input logic w64);
        return w64 ? rotr(x, 14, 1'b1) ^ rotr(x, 18, 1'b1) ^ rotr(x, 41, 1'b1)
                   : rotr(x, 6, 1'b0) ^ rotr(x, 11, 1'b0) ^ rotr(x, 25, 1'b0);
    endfunction

    function automatic logic [63:0] ssig0(input logic [63:0] x, input logic w64);
        return w64 ? rotr(x, 1, 1'b1) ^ rotr(x, 8, 1'b1) ^ (x >> 7)
                   : rotr(x, 7, 1'b0) ^ rotr(x, 18, 1'b0) ^ {32'b0, x[31:0] >> 3};
    endfunction

    function automatic logic [63:0] ssig1(input logic [63:0] x, input logic w64);
        return w64 ? rotr(x, 19, 1'b1) ^ rotr(x, 61, 1'b1) ^ (x >> 6)
                   : rotr(x, 17, 1'b0) ^ rotr(x, 19, 1'b0) ^ {32'b0, x[31:0] >> 10};
    endfunction

    // Right-justified digest, H0 most significant, upper bits zero.
    function automatic hash_t truncate(input words8_t h, input mode_t m);
        case (m)
            sha224:     return {288'b0, h[0][31:0], h[1][31:0], h[2][31:0], h[3][31:0],
                                h[4][31:0], h[5][31:0], h[6][31:0]};
            sha256:     return {256'b0, h[0][31:0], h[1][31:0], h[2][31:0], h[3][31:0],
                                h[4][31:0], h[5][31:0], h[6][31:0], h[7][31:0]};
            sha384:     return {128'b0, h[0], h[1], h[2], h[3], h[4], h[5]};
            sha512:     return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
            sha512_256: return {256'b0, h[0], h[1], h[2], h[3]};
            sha512_224: return {288'b0, h[0], h[1], h[2], h[3][63:32]};
            default:    return '0;
        endcase
    endfunction

endpackage

// File: rtl/sha_core_engine_if.sv
// Block-level handshake between the SHA bus front-end (master) and the engine (slave).
interface sha_engine_if (input logic clk, input logic rstn);
    import sha_core_engine_pkg::*;

    mode_t          mode;
    logic           new_msg;
    logic           valid;
    logic [1023:0]  msg;
    logic           ready;
    hash_t          hash;

    modport slave  (input clk, rstn, mode, new_msg, valid, msg, output ready, hash);
    modport master (input clk, rstn, ready, hash, output mode, new_msg, valid, msg);
endinterface

// File: rtl/sha_core_engine_msg_sched.sv
// 16-word message schedule window; window[0] is W[t] for the current round.
module sha_msg_sched
    import sha_core_engine_pkg::*;
(
    input  logic           clk,
    input  logic           rstn,
    input  logic           load,
    input  logic           shift,
    input  logic           w64,
    input  logic [1023:0]  block,
    output logic [63:0]    w_t
);
    logic [63:0] win [16];
    logic [63:0] w_next;

    // W[t+16] from the window positions t+14, t+9, t+1 and t.
    assign w_next = (ssig1(win[14], w64) + win[9] + ssig0(win[1], w64) + win[0]) & word_mask(w64);
    assign w_t    = win[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++)
                win[i] <= w64 ? block[1023 - 64*i -: 64] : {32'b0, block[511 - 32*i -: 32]};
        end else if (shift) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
            win[15] <= w_next;
        end
    end
endmodule

// File: rtl/sha_core_engine.sv
// Iterative SHA-2 compression: one round per clock, block chaining through the H registers.
module sha_core_engine
    import sha_core_engine_pkg::*;
(
    sha_engine_if.slave bus
);
    logic        clk, rstn;
    state_t      state;
    mode_t       mode_q, mode_eff;
    logic [6:0]  rnd, last_rnd;
    words8_t     h_q, v_q, iv, h_sum, v_next;
    logic        ready_q;
    hash_t       hash_q;
    logic        accept, w64, sched_w64;
    logic [63:0] mask, k_t, w_t, t1, t2;

    assign clk  = bus.clk;
    assign rstn = bus.rstn;

    assign accept   = (state == st_idle) && bus.valid && is_sha2(bus.mode);
    // A continuation keeps the mode of the message in progress; after reset there is none.
    assign mode_eff  = (bus.new_msg || !is_sha2(mode_q)) ? bus.mode : mode_q;
    assign w64       = is_w64(mode_q);
    assign sched_w64 = accept ? is_w64(mode_eff) : w64;
    assign last_rnd  = w64 ? 7'd79 : 7'd63;

    sha_msg_sched u_sched (
        .clk   (clk),
        .rstn  (rstn),
        .load  (accept),
        .shift (state == st_run),
        .w64   (sched_w64),
        .block (bus.msg),
        .w_t   (w_t)
    );

    always_comb begin
        iv   = iv_of(mode_eff);
        mask = word_mask(w64);
        k_t  = w64 ? K512[rnd] : {32'b0, K256[rnd[5:0]]};
        t1   = (v_q[7] + bsig1(v_q[4], w64) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + k_t + w_t) & mask;
        t2   = (bsig0(v_q[0], w64) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]))) & mask;
        v_next[0] = (t1 + t2) & mask;
        v_next[1] = v_q[0];
        v_next[2] = v_q[1];
        v_next[3] = v_q[2];
        v_next[4] = (v_q[3] + t1) & mask;
        v_next[5] = v_q[4];
        v_next[6] = v_q[5];
        v_next[7] = v_q[6];
        for (int i = 0; i < 8; i++) h_sum[i] = (h_q[i] + v_q[i]) & mask;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= st_idle;
            mode_q  <= sha1;
            rnd     <= '0;
            ready_q <= 1'b1;
            hash_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= '0;
                v_q[i] <= '0;
            end
        end else begin
            case (state)
                st_idle: if (accept) begin
                    mode_q  <= mode_eff;
                    rnd     <= '0;
                    ready_q <= 1'b0;
                    state   <= st_run;
                    for (int i = 0; i < 8; i++) begin
                        if (bus.new_msg) h_q[i] <= iv[i];
                        v_q[i] <= bus.new_msg ? iv[i] : h_q[i];
                    end
                end
                st_run: begin
                    v_q <= v_next;
                    if (rnd == last_rnd) state <= st_fin;
                    else                 rnd   <= rnd + 7'd1;
                end
                st_fin: begin
                    h_q     <= h_sum;
                    hash_q  <= truncate(h_sum, mode_q);
                    ready_q <= 1'b1;
                    state   <= st_idle;
                end
                default: state <= st_idle;
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.hash  = hash_q;
endmodule

// File: tb/tb_sha_core_engine.sv
// Scoreboarded bench for sha_core_engine: known digests, latency, robustness and reset.
module tb_sha_core_engine;
    import sha_core_engine_pkg::*;

    typedef struct {
        string name;
        hash_t exp;
        hash_t mask;
    } exp_t;

    localparam hash_t H256_HELLO = 512'h7f83b1657ff1fc53b92dc18148a1d65dfc2d4b1fa3d677284addd200126d9069;
    localparam hash_t H512_HELLO = 512'h861844d6704e8573fec34d967e20bcfef3d424cf48be04e6dc08f2bd58c729743371015ead891cc3cf1c9d34b49264b510751b1ff9e537937bc46b5d6ff4ecc8;
    localparam hash_t H256_TWO   = 512'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sha_engine_if bus_if (.clk(clk), .rstn(rstn));
    sha_core_engine dut (.bus(bus_if));

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [1023:0] hello_blk(input bit w64);
        logic [1023:0] b;
        b = '0;
        if (w64) begin
            b[1023:928] = 96'h48656c6c6f20576f726c6421;
            b[927:920]  = 8'h80;
            b[127:0]    = 128'd96;
        end else begin
            b[511:416]  = 96'h48656c6c6f20576f726c6421;
            b[415:408]  = 8'h80;
            b[63:0]     = 64'd96;
        end
        return b;
    endfunction

    function automatic exp_t full(input string nm, input hash_t h);
        exp_t e;
        e.name = nm;
        e.exp  = h;
        e.mask = '1;
        return e;
    endfunction

    // Top 32 and low bits of a width-bit digest, plus all bits above width forced zero.
    function automatic exp_t frag(input string nm, input int width, input logic [31:0] hi,
                                  input logic [31:0] lo, input int lo_bits);
        exp_t e;
        e.name = nm;
        e.exp  = '0;
        e.mask = '0;
        for (int i = width; i < 512; i++) e.mask[i] = 1'b1;
        for (int i = 0; i < 32; i++) begin
            e.mask[width - 32 + i] = 1'b1;
            e.exp[width - 32 + i]  = hi[i];
        end
        for (int i = 0; i < lo_bits; i++) begin
            e.mask[i] = 1'b1;
            e.exp[i]  = lo[i];
        end
        return e;
    endfunction

    task automatic start_block(input mode_t m, input logic nm, input logic [1023:0] blk);
        @(negedge clk);
        bus_if.mode    = m;
        bus_if.new_msg = nm;
        bus_if.msg     = blk;
        bus_if.valid   = 1'b1;
        @(posedge clk);
        #1;
        bus_if.valid   = 1'b0;
        bus_if.new_msg = 1'b0;
        checks++;
        if (bus_if.ready !== 1'b0) begin
            failures++;
            $display("FAIL accept_ready_low: ready=%b want 0", bus_if.ready);
        end
    endtask

    task automatic finish_block(input int exp_lat, input bit chk, input bit garble);
        int cyc;
        exp_t e;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus_if.ready === 1'b1) break;
            if (garble && cyc < 50) begin
                bus_if.valid   = 1'($urandom);
                bus_if.new_msg = 1'($urandom);
                bus_if.msg     = {32{$urandom}};
                bus_if.mode    = mode_t'(3'($urandom));
            end else begin
                bus_if.valid = 1'b0;
            end
        end
        checks++;
        if (cyc != exp_lat) begin
            failures++;
            $display("FAIL latency: got %0d cycles want %0d", cyc, exp_lat);
        end
        if (chk) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: got 0 entries want 1");
            end else begin
                e = sb.pop_front();
                if ((bus_if.hash & e.mask) !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got %h want %h (mask %h)", e.name, bus_if.hash, e.exp, e.mask);
                end
            end
        end
    endtask

    task automatic test_reset();
        bus_if.mode    = sha1;
        bus_if.new_msg = 1'b0;
        bus_if.valid   = 1'b0;
        bus_if.msg     = '0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_if.ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", bus_if.ready);
        end
        checks++;
        if (bus_if.hash !== '0) begin
            failures++;
            $display("FAIL reset_hash: got %h want 0", bus_if.hash);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_sha256();
        sb.push_back(full("sha256_hello", H256_HELLO));
        start_block(sha256, 1'b1, hello_blk(1'b0));
        finish_block(65, 1'b1, 1'b0);
    endtask

    task automatic test_sha512();
        sb.push_back(full("sha512_hello", H512_HELLO));
        start_block(sha512, 1'b1, hello_blk(1'b1));
        finish_block(81, 1'b1, 1'b0);
    endtask

    task automatic test_truncated();
        sb.push_back(frag("sha384_hello", 384, 32'hbfd76c0e, 32'h06adba4a, 28));
        start_block(sha384, 1'b1, hello_blk(1'b1));
        finish_block(81, 1'b1, 1'b0);
        sb.push_back(frag("sha512_256_hello", 256, 32'hf371319e, 32'h2267581a, 32));
        start_block(sha512_256, 1'b1, hello_blk(1'b1));
        finish_block(81, 1'b1, 1'b0);
        sb.push_back(frag("sha512_224_hello", 224, 32'hba0702dd, 32'h00006eae, 16));
        start_block(sha512_224, 1'b1, hello_blk(1'b1));
        finish_block(81, 1'b1, 1'b0);
        sb.push_back(frag("sha224_hello", 224, 32'h4575bb4e, 32'h530a7a1b, 32));
        start_block(sha224, 1'b1, hello_blk(1'b0));
        finish_block(65, 1'b1, 1'b0);
    endtask

    task automatic test_two_block();
        logic [1023:0] b1, b2;
        b1 = '0;
        b2 = '0;
        b1[511:64] = 448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071;
        b1[63:56]  = 8'h80;
        b2[63:0]   = 64'd448;
        start_block(sha256, 1'b1, b1);
        finish_block(65, 1'b0, 1'b0);
        sb.push_back(full("sha256_two_block", H256_TWO));
        start_block(sha256, 1'b0, b2);
        finish_block(65, 1'b1, 1'b0);
    endtask

    task automatic test_mid_toggle();
        sb.push_back(full("sha256_garbled_inputs", H256_HELLO));
        start_block(sha256, 1'b1, hello_blk(1'b0));
        finish_block(65, 1'b1, 1'b1);
    endtask

    task automatic test_unsupported();
        mode_t bad [2];
        bad[0] = sha1;
        bad[1] = mode_t'(3'd7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus_if.mode    = (k < 2) ? bad[k] : sha256;
            bus_if.new_msg = 1'b1;
            bus_if.valid   = (k < 2);
            bus_if.msg     = hello_blk(1'b1);
            repeat (3) begin
                @(posedge clk);
                #1;
                checks++;
                if (bus_if.ready !== 1'b1) begin
                    failures++;
                    $display("FAIL ignored_block_ready: mode=%0d got %b want 1", k, bus_if.ready);
                end
            end
            checks++;
            if (bus_if.hash !== H256_HELLO) begin
                failures++;
                $display("FAIL ignored_block_hash: got %h want %h", bus_if.hash, H256_HELLO);
            end
        end
        @(negedge clk);
        bus_if.valid   = 1'b0;
        bus_if.new_msg = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        start_block(sha256, 1'b1, hello_blk(1'b0));
        repeat (30) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (bus_if.ready !== 1'b1) begin
            failures++;
            $display("FAIL midrun_reset_ready: got %b want 1", bus_if.ready);
        end
        checks++;
        if (bus_if.hash !== '0) begin
            failures++;
            $display("FAIL midrun_reset_hash: got %h want 0", bus_if.hash);
        end
        @(negedge clk);
        rstn = 1'b1;
        sb.push_back(full("sha256_after_reset", H256_HELLO));
        start_block(sha256, 1'b1, hello_blk(1'b0));
        finish_block(65, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sha256();
        test_sha512();
        test_truncated();
        test_two_block();
        test_mid_toggle();
        test_unsupported();
        test_reset_mid_run();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
